// File: rtl/bcd_serial_addsub.sv
// Digit-serial signed BCD add/sub (sign-magnitude), LSD first through bcd_add; optional input check via BCD_INPUT_CHECK_EN.
// Latency: done NDIG+1 cycles after accept, 2*NDIG+1 when the result needs recomplementing.
// Backpressure: ready low while busy; start without ready is dropped, never queued.

module bcd_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (raw > 5'd9) begin
            sum  = raw[3:0] + 4'd6;
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end
endmodule

module bcd_serial_addsub #(
    parameter int NDIG = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op_sub,
    input  logic                a_sign,
    input  logic [4*NDIG-1:0]   a_bcd,
    input  logic                b_sign,
    input  logic [4*NDIG-1:0]   b_bcd,
    output logic                ready,
    output logic                done,
    output logic                res_sign,
    output logic [4*NDIG-1:0]   res_bcd,
    output logic                ovf,
    output logic                err
);
    localparam int W  = 4 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, ADD, RECOMP, FIN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    a_q, b_q, acc, acc_sh;
    logic            eff_sub_q, a_sign_q, sign_q, ovf_q, bad_q;
    logic            eff_sub, last;
    logic [3:0]      add_a, add_b, add_sum;
    logic            add_cout;

    function automatic logic [W-1:0] nines(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        return r;
    endfunction

    function automatic logic any_bad(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NDIG; i++) r = r | (v[4*i +: 4] > 4'd9);
        return r;
    endfunction

    assign eff_sub = a_sign ^ b_sign ^ op_sub;
    assign last    = (cnt == CW'(NDIG - 1));
    assign ready   = (state == IDLE);

    // RECOMP reuses the adder as (9 - d) + carry to form the 10's complement
    always_comb begin
        add_a = a_q[3:0];
        add_b = b_q[3:0];
        if (state == RECOMP) begin
            add_a = 4'd9 - acc[3:0];
            add_b = 4'd0;
        end
    end

    bcd_add u_bcd_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        acc_sh            = acc >> 4;
        acc_sh[W-1 -: 4]  = add_sum;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last) state_nxt = (eff_sub_q && !add_cout) ? RECOMP : FIN;
            RECOMP:  if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            eff_sub_q <= 1'b0;
            a_sign_q  <= 1'b0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q       <= a_bcd;
                    b_q       <= eff_sub ? nines(b_bcd) : b_bcd;
                    carry     <= eff_sub;
                    cnt       <= '0;
                    eff_sub_q <= eff_sub;
                    a_sign_q  <= a_sign;
                    bad_q     <= any_bad(a_bcd) | any_bad(b_bcd);
                end
                ADD: begin
                    acc   <= acc_sh;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    carry <= add_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cnt <= '0;
                        if (!eff_sub_q) begin
                            sign_q <= a_sign_q;
                            ovf_q  <= add_cout;
                        end else if (add_cout) begin
                            sign_q <= a_sign_q;
                            ovf_q  <= 1'b0;
                        end else begin
                            sign_q <= ~a_sign_q;
                            ovf_q  <= 1'b0;
                            carry  <= 1'b1;
                        end
                    end
                end
                RECOMP: begin
                    acc   <= acc_sh;
                    carry <= add_cout;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result outputs only change at FIN; they hold across later requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            res_sign <= 1'b0;
            res_bcd  <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (state == FIN) begin
`ifdef BCD_INPUT_CHECK_EN
                if (bad_q) begin
                    res_sign <= 1'b0;
                    res_bcd  <= '0;
                    ovf      <= 1'b0;
                end else begin
                    res_sign <= ovf_q ? sign_q : (sign_q & (|acc));
                    res_bcd  <= acc;
                    ovf      <= ovf_q;
                end
`else
                res_sign <= ovf_q ? sign_q : (sign_q & (|acc));
                res_bcd  <= acc;
                ovf      <= ovf_q;
`endif
            end
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             err <= 1'b0;
        else if (state == FIN)  err <= bad_q;
    end
`else
    assign err = 1'b0;
    logic unused_bad;
    assign unused_bad = bad_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub (NDIG=3).
module tb_bcd_serial_addsub;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic        a_sign = 1'b0;
    logic [11:0] a_bcd = '0;
    logic        b_sign = 1'b0;
    logic [11:0] b_bcd = '0;
    logic        ready, done, res_sign, ovf, err;
    logic [11:0] res_bcd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.NDIG(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sub   (op_sub),
        .a_sign   (a_sign),
        .a_bcd    (a_bcd),
        .b_sign   (b_sign),
        .b_bcd    (b_bcd),
        .ready    (ready),
        .done     (done),
        .res_sign (res_sign),
        .res_bcd  (res_bcd),
        .ovf      (ovf),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Drives one request, returns cycles from the accept edge until done is seen
    task automatic run_op(input logic sub, input logic as, input logic [11:0] a,
                          input logic bs, input logic [11:0] b, output int lat);
        op_sub = sub; a_sign = as; a_bcd = a; b_sign = bs; b_bcd = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input int lat, input int exp_lat,
                              input logic s, input logic [11:0] m, input logic o);
        check({tag, "_lat"},   lat,      exp_lat);
        check({tag, "_sign"},  res_sign, s);
        check({tag, "_bcd"},   res_bcd,  m);
        check({tag, "_ovf"},   ovf,      o);
    endtask

    initial begin
        int lat;
        int dones;
        logic [11:0] seen;

        #12;
        check("rst_ready", ready, 1'b1);
        check("rst_done",  done,  1'b0);
        check("rst_sign",  res_sign, 1'b0);
        check("rst_bcd",   res_bcd,  12'h000);
        check("rst_ovf",   ovf,   1'b0);
        check("rst_err",   err,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 1'b0, 12'h123, 1'b0, 12'h456, lat);
        expect_res("add579", lat, 4, 1'b0, 12'h579, 1'b0);
        check("b2b_ready", ready, 1'b1);

        run_op(1'b1, 1'b0, 12'h500, 1'b0, 12'h123, lat);
        expect_res("sub377", lat, 4, 1'b0, 12'h377, 1'b0);

        run_op(1'b1, 1'b0, 12'h123, 1'b0, 12'h500, lat);
        expect_res("neg377", lat, 7, 1'b1, 12'h377, 1'b0);

        run_op(1'b0, 1'b0, 12'h999, 1'b0, 12'h001, lat);
        expect_res("ovf", lat, 4, 1'b0, 12'h000, 1'b1);

        run_op(1'b0, 1'b1, 12'h250, 1'b0, 12'h250, lat);
        expect_res("zero", lat, 4, 1'b0, 12'h000, 1'b0);

        // -300 + -200: same signs add magnitudes, sign follows A
        run_op(1'b0, 1'b1, 12'h300, 1'b1, 12'h200, lat);
        expect_res("negadd", lat, 4, 1'b1, 12'h500, 1'b0);

        // second start while busy must be dropped
        op_sub = 1'b0; a_sign = 1'b0; a_bcd = 12'h111; b_sign = 1'b0; b_bcd = 12'h222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a_bcd = 12'h900; b_bcd = 12'h900; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        seen  = '0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dones++;
                seen = res_bcd;
            end
            @(posedge clk); #1;
        end
        check("ign_dones", dones, 1);
        check("ign_res",   seen,  12'h333);
        check("ign_hold",  res_bcd, 12'h333);

        // reset during ADD
        op_sub = 1'b0; a_bcd = 12'h444; b_bcd = 12'h111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", ready,   1'b1);
        check("mid_rst_done",  done,    1'b0);
        check("mid_rst_bcd",   res_bcd, 12'h000);
        check("mid_rst_sign",  res_sign, 1'b0);
        check("mid_rst_ovf",   ovf,     1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("mid_rst_nodone", dones, 0);

        run_op(1'b0, 1'b0, 12'h001, 1'b0, 12'h001, lat);
        expect_res("fresh", lat, 4, 1'b0, 12'h002, 1'b0);

        run_op(1'b0, 1'b0, 12'h1A3, 1'b0, 12'h001, lat);
        check("bad_lat", lat, 4);
`ifdef BCD_INPUT_CHECK_EN
        check("bad_err",  err,      1'b1);
        check("bad_bcd",  res_bcd,  12'h000);
        check("bad_sign", res_sign, 1'b0);
        check("bad_ovf",  ovf,      1'b0);
`else
        check("bad_err",  err,      1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
